pwm_sweep_ctrl: RTL and testbench
=================================

Name: pwm_sweep_ctrl

Overview:
- Autonomous duty-cycle sweep controller for the PWM register bank.
- Sits between the host-side decoder and the register bank, and shares the bank's single read/write port between the two.
- The host has absolute priority on the port.
- On start, the controller programs PERIOD, COMPARE1, COUNTER_RESET, COUNTER_EN and PWM_EN, then steps COMPARE1 every N counter periods and shuts the PWM down on stop.

Parameters:
- WRAP_MODE, 1: at compare overflow, 1 = reload cmp_min and continue; 0 = finish (DONE).
- TICK_W, 8: width of the periods-per-step counter.

Ports:
- clk  in  1  peripheral clock
- rst_n  in  1  reset, asynchronous, active-low
- host_read  in  1  decoder read strobe
- host_write  in  1  decoder write strobe
- host_addr  in  6  decoder address
- host_wdata  in  8  decoder write data
- host_rdata  out  8  read data returned to decoder (combinational from data_read)
- read  out  1  to register bank
- write  out  1  to register bank
- addr  out  6  to register bank
- data_write  out  8  to register bank
- data_read  in  8  from register bank
- counter_val  in  16  live counter value
- start  in  1  single-cycle start pulse
- stop  in  1  single-cycle stop pulse
- period_cfg  in  16  PERIOD to program
- cmp_min  in  16  initial/reload COMPARE1
- cmp_max  in  16  upper COMPARE1 bound
- step  in  16  COMPARE1 increment
- periods_per_step  in  TICK_W  counter periods between steps; 0 treated as 1
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE
- cur_cmp  out  16  last COMPARE1 value fully written (both bytes)

Behaviour:
- **Reset values:** all outputs 0, state IDLE, tick counter 0.
- **Port mux (combinational):**
  - If host_read or host_write is high, read/write/addr/data_write come from the host.
  - Otherwise they come from the sequencer (read=0, write=seq_wr).
  - host_rdata = data_read always.
- **Blocked writes:** a sequencer write is accepted only in a cycle with no host access. A blocked write is held with the same addr/data and retried every cycle; the FSM does not advance until it is accepted.
- **States:** IDLE, INIT (write list), RUN, UPD_L, UPD_H, SHUT, DONE.
- **INIT:** one accepted write per cycle, in this order:
  - 0x00 period_cfg[7:0]
  - 0x01 period_cfg[15:8]
  - 0x03 cmp_min[7:0]
  - 0x04 cmp_min[15:8]
  - 0x07 (any data)
  - 0x02 = 1
  - 0x0C = 1
  - → RUN.
  - Latency with an idle host: 7 cycles from start to RUN; cur_cmp = cmp_min after the 0x04 write.
- **RUN:**
  - Period tick = counter_val == 0 while the registered previous value != 0.
  - Tick counter increments on each period tick. When it reaches max(periods_per_step,1): clear it and compute nxt = cmp + step in 17 bits.
    - If nxt > cmp_max: WRAP_MODE=1 → nxt = cmp_min; WRAP_MODE=0 → SHUT then DONE.
  - Otherwise → UPD_L.
- **Update:** UPD_L writes 0x03 nxt[7:0]; UPD_H writes 0x04 nxt[15:8]; then cur_cmp = nxt → RUN.
  - Period ticks during UPD_L/UPD_H are counted.
  - Torn LSB/MSB exposure for one cycle is accepted.
- **SHUT:** writes 0x0C = 0, then 0x02 = 0 → IDLE (on stop) or DONE (on WRAP_MODE=0 finish).
- **stop:**
  - In INIT, RUN, UPD_L or UPD_H: finish any in-flight write, then → SHUT.
  - In IDLE or DONE: ignored.
  - start in DONE → INIT. start in any busy state is ignored.
  - start and stop in the same cycle in IDLE: stop wins, no action.
- **Edge cases:**
  - step = 0 is legal: updates rewrite the same value.
  - period_cfg = 0: no ticks ever occur; RUN holds indefinitely.
  - Config inputs are sampled live; they must be stable while busy.
  - Host writes to 0x03/0x04 during RUN take effect but are overwritten at the next step.
  - Async reset in any state → IDLE immediately, outputs 0, no shutdown writes. The register bank resets on the same rst_n.

Decomposition:
- **Shared package pwm_regmap_pkg:** register address localparams (ADDR_PERIOD_L … ADDR_FUNCTIONS = 0x00 … 0x0D) and a state enum for the FSM.
- **Sub-module pwm_period_tick:** zero-crossing detector plus periods-per-step counter, outputting step_due.
- The port mux stays inline.

Test Plan:
- **Start, idle host:** start with period_cfg=0x0123, cmp_min=0x0010 → writes 00:23, 01:01, 03:10, 04:00, 07, 02:01, 0C:01 on 7 consecutive cycles; busy=1.
- **Host contention:** host_write held 3 cycles during INIT at the 0x03 step → host writes pass through unchanged; 0x03:10 issued on the 4th cycle; order preserved.
- **Stepping:** step=0x0040, cmp_max=0x0100, periods_per_step=2, WRAP_MODE=1, counter wrapping → COMPARE1 goes 0x10→0x50→0x90→0xD0→0x10 every 2 ticks; cur_cmp matches after each MSB write.
- **Finish:** WRAP_MODE=0, same config → after 0xD0 the next step writes 0C:00, 02:00; done=1, busy=0.
- **Stop mid-run:** stop during UPD_L → UPD_L completes, 0C:00 and 02:00 written, then IDLE.
- **Reset mid-INIT:** rst_n low after the 0x03 write → write=0 and outputs 0 asynchronously; a fresh start restarts the write list at 0x00.

Source files
------------

// File: rtl/pwm_regmap_pkg.sv
// PWM register bank address map and the sweep controller state encoding.
// Shared by the sweep controller and anything else that talks to the bank.
package pwm_regmap_pkg;

  localparam logic [5:0] ADDR_PERIOD_L      = 6'h00;
  localparam logic [5:0] ADDR_PERIOD_H      = 6'h01;
  localparam logic [5:0] ADDR_COUNTER_EN    = 6'h02;
  localparam logic [5:0] ADDR_COMPARE1_L    = 6'h03;
  localparam logic [5:0] ADDR_COMPARE1_H    = 6'h04;
  localparam logic [5:0] ADDR_COMPARE2_L    = 6'h05;
  localparam logic [5:0] ADDR_COMPARE2_H    = 6'h06;
  localparam logic [5:0] ADDR_COUNTER_RESET = 6'h07;
  localparam logic [5:0] ADDR_COUNTER_L     = 6'h08;
  localparam logic [5:0] ADDR_COUNTER_H     = 6'h09;
  localparam logic [5:0] ADDR_STATUS        = 6'h0A;
  localparam logic [5:0] ADDR_IRQ_EN        = 6'h0B;
  localparam logic [5:0] ADDR_PWM_EN        = 6'h0C;
  localparam logic [5:0] ADDR_FUNCTIONS     = 6'h0D;

  // Index of the last entry in the start-up write list.
  localparam logic [2:0] INIT_LAST = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_UPD_L,
    ST_UPD_H,
    ST_SHUT,
    ST_DONE
  } sweep_state_e;

endpackage

// File: rtl/pwm_period_tick.sv
// Detects counter wrap-to-zero and counts periods, raising step_due once every
// max(periods_per_step,1) periods until the controller acknowledges it.
module pwm_period_tick #(
  parameter int TICK_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       counter_val,
  input  logic              enable,
  input  logic [TICK_W-1:0] periods_per_step,
  input  logic              step_ack,
  output logic              step_due
);

  logic              prev_nonzero;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W:0]   cnt_inc;
  logic [TICK_W:0]   limit;
  logic              period_tick;
  logic              reach;

  assign period_tick = (counter_val == 16'd0) && prev_nonzero;
  assign cnt_inc     = {1'b0, tick_cnt} + {{TICK_W{1'b0}}, 1'b1};
  assign limit       = (periods_per_step == '0) ? {{TICK_W{1'b0}}, 1'b1}
                                                : {1'b0, periods_per_step};
  assign reach       = period_tick && (cnt_inc >= limit);

  // A due step stays pending so a period ending during an update is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_nonzero <= 1'b0;
      tick_cnt     <= '0;
      step_due     <= 1'b0;
    end else begin
      prev_nonzero <= (counter_val != 16'd0);
      if (!enable) begin
        tick_cnt <= '0;
        step_due <= 1'b0;
      end else begin
        if (reach) begin
          tick_cnt <= '0;
          step_due <= 1'b1;
        end else begin
          if (period_tick) begin
            tick_cnt <= cnt_inc[TICK_W-1:0];
          end
          if (step_ack) begin
            step_due <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pwm_sweep_ctrl.sv
// Duty-cycle sweep controller: programs the PWM bank, steps COMPARE1 every N
// periods and shares the bank port with the host, which always has priority.
module pwm_sweep_ctrl
  import pwm_regmap_pkg::*;
#(
  parameter int WRAP_MODE = 1,
  parameter int TICK_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_read,
  input  logic              host_write,
  input  logic [5:0]        host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              read,
  output logic              write,
  output logic [5:0]        addr,
  output logic [7:0]        data_write,
  input  logic [7:0]        data_read,
  input  logic [15:0]       counter_val,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       period_cfg,
  input  logic [15:0]       cmp_min,
  input  logic [15:0]       cmp_max,
  input  logic [15:0]       step,
  input  logic [TICK_W-1:0] periods_per_step,
  output logic              busy,
  output logic              done,
  output logic [15:0]       cur_cmp
);

  sweep_state_e state, state_d;
  logic [2:0]   idx, idx_d;
  logic [15:0]  cmp_q, cmp_d;
  logic [15:0]  nxt_q, nxt_d;
  logic         stop_pend, stop_pend_d;
  logic         shut_done, shut_done_d;

  logic         host_active;
  logic         seq_wr;
  logic [5:0]   seq_addr;
  logic [7:0]   seq_data;
  logic         seq_accept;
  logic         stop_req;
  logic         step_due;
  logic         step_ack;
  logic         tick_en;
  logic [16:0]  sum17;
  logic         ovf;

  assign host_active = host_read | host_write;
  assign seq_accept  = seq_wr & ~host_active;
  assign stop_req    = stop | stop_pend;
  assign tick_en     = (state == ST_RUN) || (state == ST_UPD_L) || (state == ST_UPD_H);
  assign sum17       = {1'b0, cmp_q} + {1'b0, step};
  assign ovf         = sum17 > {1'b0, cmp_max};

  assign busy        = (state != ST_IDLE) && (state != ST_DONE);
  assign done        = (state == ST_DONE);
  assign cur_cmp     = cmp_q;
  assign host_rdata  = data_read;

  pwm_period_tick #(
    .TICK_W(TICK_W)
  ) u_tick (
    .clk              (clk),
    .rst_n            (rst_n),
    .counter_val      (counter_val),
    .enable           (tick_en),
    .periods_per_step (periods_per_step),
    .step_ack         (step_ack),
    .step_due         (step_due)
  );

  // Bank port: the host wins outright; a blocked sequencer write simply repeats.
  always_comb begin
    if (host_active) begin
      read       = host_read;
      write      = host_write;
      addr       = host_addr;
      data_write = host_wdata;
    end else begin
      read       = 1'b0;
      write      = seq_wr;
      addr       = seq_addr;
      data_write = seq_data;
    end
  end

  always_comb begin
    seq_wr   = 1'b0;
    seq_addr = '0;
    seq_data = '0;
    case (state)
      ST_INIT: begin
        seq_wr = 1'b1;
        case (idx)
          3'd0: begin seq_addr = ADDR_PERIOD_L;      seq_data = period_cfg[7:0];  end
          3'd1: begin seq_addr = ADDR_PERIOD_H;      seq_data = period_cfg[15:8]; end
          3'd2: begin seq_addr = ADDR_COMPARE1_L;    seq_data = cmp_min[7:0];     end
          3'd3: begin seq_addr = ADDR_COMPARE1_H;    seq_data = cmp_min[15:8];    end
          3'd4: begin seq_addr = ADDR_COUNTER_RESET; seq_data = 8'h00;            end
          3'd5: begin seq_addr = ADDR_COUNTER_EN;    seq_data = 8'h01;            end
          3'd6: begin seq_addr = ADDR_PWM_EN;        seq_data = 8'h01;            end
          default: seq_wr = 1'b0;
        endcase
      end
      ST_UPD_L: begin
        seq_wr   = 1'b1;
        seq_addr = ADDR_COMPARE1_L;
        seq_data = nxt_q[7:0];
      end
      ST_UPD_H: begin
        seq_wr   = 1'b1;
        seq_addr = ADDR_COMPARE1_H;
        seq_data = nxt_q[15:8];
      end
      ST_SHUT: begin
        seq_wr   = 1'b1;
        seq_addr = (idx == 3'd0) ? ADDR_PWM_EN : ADDR_COUNTER_EN;
        seq_data = 8'h00;
      end
      default: ;
    endcase
  end

  // A stop seen while a write is still blocked is remembered until it lands.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    cmp_d       = cmp_q;
    nxt_d       = nxt_q;
    stop_pend_d = stop_pend;
    shut_done_d = shut_done;
    step_ack    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d     = ST_INIT;
          idx_d       = 3'd0;
          stop_pend_d = 1'b0;
          shut_done_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d     = ST_INIT;
          idx_d       = 3'd0;
          stop_pend_d = 1'b0;
          shut_done_d = 1'b0;
        end
      end
      ST_INIT: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (seq_accept) begin
          if (idx == 3'd3) begin
            cmp_d = cmp_min;
          end
          if (stop_req) begin
            state_d     = ST_SHUT;
            idx_d       = 3'd0;
            stop_pend_d = 1'b0;
            shut_done_d = 1'b0;
          end else if (idx == INIT_LAST) begin
            state_d = ST_RUN;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx + 3'd1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d     = ST_SHUT;
          idx_d       = 3'd0;
          shut_done_d = 1'b0;
        end else if (step_due) begin
          step_ack = 1'b1;
          if (ovf && (WRAP_MODE == 0)) begin
            state_d     = ST_SHUT;
            idx_d       = 3'd0;
            shut_done_d = 1'b1;
          end else begin
            nxt_d   = ovf ? cmp_min : sum17[15:0];
            state_d = ST_UPD_L;
          end
        end
      end
      ST_UPD_L, ST_UPD_H: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (seq_accept) begin
          if (state == ST_UPD_H) begin
            cmp_d = nxt_q;
          end
          if (stop_req) begin
            state_d     = ST_SHUT;
            idx_d       = 3'd0;
            stop_pend_d = 1'b0;
            shut_done_d = 1'b0;
          end else begin
            state_d = (state == ST_UPD_L) ? ST_UPD_H : ST_RUN;
          end
        end
      end
      ST_SHUT: begin
        if (seq_accept) begin
          if (idx == 3'd0) begin
            idx_d = 3'd1;
          end else begin
            idx_d   = 3'd0;
            state_d = shut_done ? ST_DONE : ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      cmp_q     <= '0;
      nxt_q     <= '0;
      stop_pend <= 1'b0;
      shut_done <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      cmp_q     <= cmp_d;
      nxt_q     <= nxt_d;
      stop_pend <= stop_pend_d;
      shut_done <= shut_done_d;
    end
  end

endmodule

// File: tb/tb_pwm_sweep_ctrl.sv
// Directed bench for pwm_sweep_ctrl: a wrapping and a finishing instance share
// stimulus; every bank write is logged and compared against hand-built lists.
module tb_pwm_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_read = 1'b0;
  logic        host_write = 1'b0;
  logic [5:0]  host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic [7:0]  data_read = 8'h5A;
  logic [15:0] counter_val = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] period_cfg = 16'h0123;
  logic [15:0] cmp_min = 16'h0010;
  logic [15:0] cmp_max = 16'h0100;
  logic [15:0] step = 16'h0040;
  logic [7:0]  periods_per_step = 8'd2;

  logic [7:0]  host_rdata_a, host_rdata_b;
  logic        read_a, read_b, write_a, write_b;
  logic [5:0]  addr_a, addr_b;
  logic [7:0]  data_write_a, data_write_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [15:0] cur_cmp_a, cur_cmp_b;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          c, c0;
  logic [13:0] log_a[$];
  int          cyc_a[$];
  logic [13:0] log_b[$];

  logic [13:0] init_seq [7] = '{{6'h00, 8'h23}, {6'h01, 8'h01}, {6'h03, 8'h10},
                                {6'h04, 8'h00}, {6'h07, 8'h00}, {6'h02, 8'h01},
                                {6'h0C, 8'h01}};
  logic [13:0] cont_seq [10] = '{{6'h00, 8'h23}, {6'h01, 8'h01}, {6'h20, 8'hA1},
                                 {6'h21, 8'hA2}, {6'h22, 8'hA3}, {6'h03, 8'h10},
                                 {6'h04, 8'h00}, {6'h07, 8'h00}, {6'h02, 8'h01},
                                 {6'h0C, 8'h01}};

  pwm_sweep_ctrl #(.WRAP_MODE(1), .TICK_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .host_read(host_read), .host_write(host_write),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata_a),
    .read(read_a), .write(write_a), .addr(addr_a), .data_write(data_write_a),
    .data_read(data_read), .counter_val(counter_val), .start(start), .stop(stop),
    .period_cfg(period_cfg), .cmp_min(cmp_min), .cmp_max(cmp_max), .step(step),
    .periods_per_step(periods_per_step), .busy(busy_a), .done(done_a), .cur_cmp(cur_cmp_a)
  );

  pwm_sweep_ctrl #(.WRAP_MODE(0), .TICK_W(8)) dut_nowrap (
    .clk(clk), .rst_n(rst_n), .host_read(host_read), .host_write(host_write),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata_b),
    .read(read_b), .write(write_b), .addr(addr_b), .data_write(data_write_b),
    .data_read(data_read), .counter_val(counter_val), .start(start), .stop(stop),
    .period_cfg(period_cfg), .cmp_min(cmp_min), .cmp_max(cmp_max), .step(step),
    .periods_per_step(periods_per_step), .busy(busy_b), .done(done_b), .cur_cmp(cur_cmp_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && write_a) begin
      log_a.push_back({addr_a, data_write_a});
      cyc_a.push_back(cyc);
    end
    if (rst_n && write_b) begin
      log_b.push_back({addr_b, data_write_b});
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s_start, input logic s_stop, input logic s_hw,
                               input logic [5:0] s_ha, input logic [7:0] s_hd,
                               input logic [15:0] s_cv);
    start       = s_start;
    stop        = s_stop;
    host_write  = s_hw;
    host_addr   = s_ha;
    host_wdata  = s_hd;
    counter_val = s_cv;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 16'd0);
  endtask

  task automatic periodTick();
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 16'd5);
    idleCycles(5);
  endtask

  task automatic expectA(input string tag, input logic [13:0] exp, output int cy);
    cy = -1;
    if (log_a.size() == 0) begin
      checkOutput(tag, 32'hFFFFFFFF, 32'(exp));
    end else begin
      cy = cyc_a.pop_front();
      checkOutput(tag, 32'(log_a.pop_front()), 32'(exp));
    end
  endtask

  task automatic expectB(input string tag, input logic [13:0] exp);
    if (log_b.size() == 0) checkOutput(tag, 32'hFFFFFFFF, 32'(exp));
    else checkOutput(tag, 32'(log_b.pop_front()), 32'(exp));
  endtask

  initial begin
    #12;
    checkOutput("rst_port", 32'({read_a, write_a, addr_a, data_write_a}), 32'd0);
    checkOutput("rst_status", 32'({busy_a, done_a, cur_cmp_a}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] start with idle host");
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 16'd0);
    checkOutput("first_wr", 32'({write_a, addr_a, data_write_a}), 32'({1'b1, 6'h00, 8'h23}));
    checkOutput("busy_init", 32'(busy_a), 32'd1);
    idleCycles(8);
    for (int i = 0; i < 7; i++) begin
      expectA($sformatf("init%0d", i), init_seq[i], c);
      if (i == 0) c0 = c;
      else checkOutput($sformatf("init_cyc%0d", i), 32'(c), 32'(c0 + i));
      expectB($sformatf("init_b%0d", i), init_seq[i]);
    end
    checkOutput("init_cmp", 32'(cur_cmp_a), 32'h0010);
    checkOutput("run_busy", 32'({busy_a, done_a}), 32'b10);

    $display("[TB] stepping");
    for (int k = 1; k <= 3; k++) begin
      logic [15:0] e;
      e = 16'(16'h0010 + 16'h0040 * k);
      periodTick();
      checkOutput($sformatf("no_step_one_tick%0d", k), 32'(log_a.size()), 32'd0);
      periodTick();
      expectA($sformatf("step%0d_l", k), {6'h03, e[7:0]}, c);
      expectA($sformatf("step%0d_h", k), {6'h04, e[15:8]}, c);
      expectB($sformatf("step%0d_lb", k), {6'h03, e[7:0]});
      expectB($sformatf("step%0d_hb", k), {6'h04, e[15:8]});
      checkOutput($sformatf("step%0d_cmp", k), 32'(cur_cmp_a), 32'(e));
      checkOutput($sformatf("step%0d_cmpb", k), 32'(cur_cmp_b), 32'(e));
    end
    periodTick();
    periodTick();
    expectA("wrap_l", {6'h03, 8'h10}, c);
    expectA("wrap_h", {6'h04, 8'h00}, c);
    checkOutput("wrap_cmp", 32'(cur_cmp_a), 32'h0010);
    checkOutput("wrap_busy", 32'({busy_a, done_a}), 32'b10);
    expectB("fin_pwm_off", {6'h0C, 8'h00});
    expectB("fin_cnt_off", {6'h02, 8'h00});
    checkOutput("fin_status", 32'({busy_b, done_b}), 32'b01);
    checkOutput("fin_cmp", 32'(cur_cmp_b), 32'h00D0);
    checkOutput("step_extra", 32'(log_a.size() + log_b.size()), 32'd0);

    $display("[TB] stop during UPD_L");
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 16'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 16'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 16'd0);
    idleCycles(1);
    checkOutput("updl_drive", 32'({write_a, addr_a}), 32'({1'b1, 6'h03}));
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 16'd0);
    idleCycles(4);
    expectA("stop_updl", {6'h03, 8'h50}, c);
    expectA("stop_pwm_off", {6'h0C, 8'h00}, c);
    expectA("stop_cnt_off", {6'h02, 8'h00}, c);
    checkOutput("stop_status", 32'({busy_a, done_a}), 32'b00);
    checkOutput("stop_cmp", 32'(cur_cmp_a), 32'h0010);
    checkOutput("done_ignores_stop", 32'({done_b, 6'(log_b.size())}), 32'({1'b1, 6'd0}));

    $display("[TB] host contention during start-up");
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 16'd0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h20, 8'hA1, 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h21, 8'hA2, 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h22, 8'hA3, 16'd0);
    idleCycles(8);
    for (int i = 0; i < 10; i++) begin
      expectA($sformatf("cont%0d", i), cont_seq[i], c);
      if (i == 0) c0 = c;
      else checkOutput($sformatf("cont_cyc%0d", i), 32'(c), 32'(c0 + i));
      expectB($sformatf("cont_b%0d", i), cont_seq[i]);
    end
    host_read = 1'b1;
    host_addr = 6'h0A;
    #1;
    checkOutput("host_read_mux", 32'({read_a, write_a, addr_a}), 32'({1'b1, 1'b0, 6'h0A}));
    checkOutput("host_rdata", 32'(host_rdata_a), 32'h5A);
    host_read = 1'b0;
    host_addr = 6'h00;

    $display("[TB] async reset and restart");
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_run", 32'({busy_a, done_a, cur_cmp_a}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    log_a.delete();
    cyc_a.delete();
    log_b.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h00, 8'h00, 16'd0);
    idleCycles(1);
    checkOutput("start_stop_idle", 32'({busy_a, 6'(log_a.size())}), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 16'd0);
    idleCycles(3);
    checkOutput("pre_rst_drive", 32'({write_a, addr_a, data_write_a}), 32'({1'b1, 6'h04, 8'h00}));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_init_port", 32'({read_a, write_a, addr_a, data_write_a}), 32'd0);
    checkOutput("rst_init_status", 32'({busy_a, done_a, cur_cmp_a}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expectA("pre_rst0", {6'h00, 8'h23}, c);
    expectA("pre_rst1", {6'h01, 8'h01}, c);
    expectA("pre_rst2", {6'h03, 8'h10}, c);
    checkOutput("pre_rst_extra", 32'(log_a.size()), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 16'd0);
    idleCycles(2);
    expectA("restart0", {6'h00, 8'h23}, c);
    expectA("restart1", {6'h01, 8'h01}, c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
